// File: rtl/frame_buffer_ram_if.sv
// Pixel bus for frame_buffer_ram: write/read requests, read response,
// clear control and bank status grouped behind master/slave modports.
interface frame_buffer_ram_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned COORD_W = 8
);
    // Pixel write request
    logic               w_en;
    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic [DATA_W-1:0]  w_data;

    // Pixel read request and response
    logic               r_en;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;

    // Frame fill control and status
    logic               clear_req;
    logic [DATA_W-1:0]  clear_color;
    logic               busy;
    logic               oob_err;

    // Bank control (only meaningful in double-buffer builds)
    logic               swap;
    logic               bank;

    modport master (
        output w_en, w_x, w_y, w_data,
        output r_en, r_x, r_y,
        output clear_req, clear_color,
        output swap,
        input  r_data, r_valid, busy, oob_err, bank
    );

    modport slave (
        input  w_en, w_x, w_y, w_data,
        input  r_en, r_x, r_y,
        input  clear_req, clear_color,
        input  swap,
        output r_data, r_valid, busy, oob_err, bank
    );
endinterface

// File: rtl/frame_buffer_ram.sv
// Frame buffer: single-clock pixel RAM addressed by (x, y) with a 1-cycle
// registered read, out-of-range detection, and a clear engine that fills the
// whole frame with one color, one pixel per cycle.
// Optional macro FB_DOUBLE_BUFFER_EN: two banks, writes/clears go to the back
// bank, reads come from the front bank, swap exchanges them.
module frame_buffer_ram #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned SCREEN_WIDTH  = 176,
    parameter int unsigned SCREEN_HEIGHT = 144,
    parameter int unsigned COORD_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    frame_buffer_ram_if.slave  bus
);
    localparam int unsigned DEPTH  = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int unsigned NBANK  = 2;
`else
    localparam int unsigned NBANK  = 1;
`endif
    localparam int unsigned MEM_DEPTH = NBANK * DEPTH;
    localparam int unsigned PADDR_W   = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Clear FSM state
    state_t              r_state;
    logic [ADDR_W-1:0]   r_count;
    logic [DATA_W-1:0]   r_color;
    logic                r_busy;

    // Storage and read response
    logic [DATA_W-1:0]   r_mem [0:MEM_DEPTH-1];
    logic [DATA_W-1:0]   r_rd_word;
    logic                r_rd_zero;
    logic                r_valid;
    logic                r_oob;

    // Request decode
    logic                w_wr_inrange;
    logic                w_rd_inrange;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_bank;
    logic                w_wr_bank;
    logic                w_rd_bank;

    // RAM port signals
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_wlin;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [PADDR_W-1:0]  w_mem_waddr;
    logic [PADDR_W-1:0]  w_mem_raddr;

    // Coordinate range checks; the linear address is only trusted when in range
    assign w_wr_inrange = (32'(bus.w_x) < SCREEN_WIDTH) && (32'(bus.w_y) < SCREEN_HEIGHT);
    assign w_rd_inrange = (32'(bus.r_x) < SCREEN_WIDTH) && (32'(bus.r_y) < SCREEN_HEIGHT);

    // Linear pixel address y*SCREEN_WIDTH + x
    assign w_wr_addr = ADDR_W'(bus.w_y) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(bus.w_x);
    assign w_rd_addr = w_rd_inrange
                     ? ADDR_W'(bus.r_y) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(bus.r_x)
                     : '0;

    // Single write port shared by the clear engine (priority) and the bus;
    // nothing is written while reset is held so an aborted clear stops cleanly
    assign w_mem_we    = !reset && (r_busy || (bus.w_en && w_wr_inrange));
    assign w_mem_wlin  = r_busy ? r_count : w_wr_addr;
    assign w_mem_wdata = r_busy ? r_color : bus.w_data;

    // Writes target the back bank, reads the front bank
    assign w_wr_bank = ~w_bank;
    assign w_rd_bank = w_bank;

`ifdef FB_DOUBLE_BUFFER_EN
    logic r_bank;
    logic r_swap_pend;

    assign w_bank = r_bank;

    // Bank 1 occupies the upper DEPTH words of the array
    assign w_mem_waddr = w_wr_bank ? PADDR_W'(DEPTH) + PADDR_W'(w_mem_wlin)
                                   : PADDR_W'(w_mem_wlin);
    assign w_mem_raddr = w_rd_bank ? PADDR_W'(DEPTH) + PADDR_W'(w_rd_addr)
                                   : PADDR_W'(w_rd_addr);

    // Bank toggle: immediate when idle, deferred to the end of a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank      <= 1'b0;
            r_swap_pend <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (bus.swap) begin
                r_bank <= ~r_bank;
            end
        end else if (r_count == LAST_ADDR) begin
            if (bus.swap || r_swap_pend) begin
                r_bank <= ~r_bank;
            end
            r_swap_pend <= 1'b0;
        end else if (bus.swap) begin
            r_swap_pend <= 1'b1;
        end
    end
`else
    logic w_unused_swap;

    assign w_bank        = 1'b0;
    assign w_unused_swap = bus.swap ^ w_wr_bank ^ w_rd_bank;
    assign w_mem_waddr   = PADDR_W'(w_mem_wlin);
    assign w_mem_raddr   = PADDR_W'(w_rd_addr);
`endif

    // Clear FSM: IDLE waits for clear_req, CLEAR walks 0..DEPTH-1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_color <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        r_state <= ST_CLEAR;
                        r_count <= '0;
                        r_color <= bus.clear_color;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_count == LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM array: read-before-write, no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
        if (bus.r_en) begin
            r_rd_word <= r_mem[w_mem_raddr];
        end
    end

    // Read response flags and the out-of-range pulse, aligned with r_valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_rd_zero <= 1'b1;
            r_oob     <= 1'b0;
        end else begin
            r_valid <= bus.r_en;
            if (bus.r_en) begin
                r_rd_zero <= !w_rd_inrange;
            end
            r_oob <= (bus.r_en && !w_rd_inrange)
                  || (bus.w_en && !w_wr_inrange && !r_busy);
        end
    end

    // Out-of-range reads and the post-reset state present zero data
    assign bus.r_data  = r_rd_zero ? '0 : r_rd_word;
    assign bus.r_valid = r_valid;
    assign bus.busy    = r_busy;
    assign bus.oob_err = r_oob;
    assign bus.bank    = w_bank;
endmodule

// File: tb/tb_frame_buffer_ram.sv
// Bench for frame_buffer_ram: directed vectors, a cycle-level reference model
// of the frame buffer and a compare process checking every cycle.
module tb_frame_buffer_ram;
    localparam int W     = 176;
    localparam int H     = 144;
    localparam int DEPTH = W * H;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    frame_buffer_ram_if #(.DATA_W(8), .COORD_W(8)) bus ();

    frame_buffer_ram #(
        .DATA_W(8), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .COORD_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] m_mem   [NB][DEPTH];
    bit         m_known [NB][DEPTH];
    logic [7:0] m_data;
    bit         m_rd_known;
    bit         m_valid, m_oob, m_busy, m_pend;
    int         m_bank, m_clr_idx;
    logic [7:0] m_color;

    function automatic bit inr(input logic [7:0] x, input logic [7:0] y);
        return (int'(x) < W) && (int'(y) < H);
    endfunction

    function automatic int lin(input logic [7:0] x, input logic [7:0] y);
        return int'(y) * W + int'(x);
    endfunction

    // Model: advance one clock using the inputs the bench is holding
    always @(posedge clk) begin
        if (reset) begin
            m_valid = 0; m_data = 8'h00; m_rd_known = 1; m_oob = 0;
            m_busy = 0; m_bank = 0; m_pend = 0; m_clr_idx = 0;
        end else begin
            int wb;
            bit oob;
            oob = 0;
            wb  = (NB == 2) ? 1 - m_bank : 0;
            m_valid = bus.r_en;
            if (bus.r_en) begin
                if (inr(bus.r_x, bus.r_y)) begin
                    m_data     = m_mem[m_bank][lin(bus.r_x, bus.r_y)];
                    m_rd_known = m_known[m_bank][lin(bus.r_x, bus.r_y)];
                end else begin
                    m_data = 8'h00; m_rd_known = 1; oob = 1;
                end
            end
            if (m_busy) begin
                m_mem[wb][m_clr_idx]   = m_color;
                m_known[wb][m_clr_idx] = 1;
                m_clr_idx++;
                if (NB == 2 && bus.swap) m_pend = 1;
                if (m_clr_idx == DEPTH) begin
                    m_busy = 0;
                    if (m_pend) m_bank = 1 - m_bank;
                    m_pend = 0;
                end
            end else begin
                if (bus.w_en) begin
                    if (inr(bus.w_x, bus.w_y)) begin
                        m_mem[wb][lin(bus.w_x, bus.w_y)]   = bus.w_data;
                        m_known[wb][lin(bus.w_x, bus.w_y)] = 1;
                    end else begin
                        oob = 1;
                    end
                end
                if (NB == 2 && bus.swap) m_bank = 1 - m_bank;
                if (bus.clear_req) begin
                    m_busy = 1; m_clr_idx = 0; m_color = bus.clear_color;
                end
            end
            m_oob = oob;
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("r_valid", 32'(bus.r_valid), 32'(m_valid));
            chk("oob_err", 32'(bus.oob_err), 32'(m_oob));
            chk("busy",    32'(bus.busy),    32'(m_busy));
            chk("bank",    32'(bus.bank),    32'(m_bank));
            if (m_valid && m_rd_known) chk("r_data", 32'(bus.r_data), 32'(m_data));
        end
    end

    task automatic clr_in();
        bus.w_en = 0; bus.r_en = 0; bus.clear_req = 0; bus.swap = 0;
    endtask

    task automatic idle();
        @(negedge clk); clr_in();
    endtask

    task automatic wr(input int x, input int y, input logic [7:0] d);
        @(negedge clk); clr_in();
        bus.w_en = 1; bus.w_x = 8'(x); bus.w_y = 8'(y); bus.w_data = d;
    endtask

    task automatic rd(input int x, input int y);
        @(negedge clk); clr_in();
        bus.r_en = 1; bus.r_x = 8'(x); bus.r_y = 8'(y);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        clr_in();
        bus.w_x = 0; bus.w_y = 0; bus.w_data = 0; bus.r_x = 0; bus.r_y = 0;
        bus.clear_color = 0;
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        chk_en = 1;
        chk("reset_r_valid", 32'(bus.r_valid), 32'd0);
        chk("reset_r_data",  32'(bus.r_data),  32'd0);
        chk("reset_busy",    32'(bus.busy),    32'd0);
        chk("reset_oob",     32'(bus.oob_err), 32'd0);
        chk("reset_bank",    32'(bus.bank),    32'd0);

        // Basic write then read at (3,2), linear address 355
        wr(3, 2, 8'hA5); rd(3, 2); idle();
        chk("rd_3_2_valid", 32'(bus.r_valid), 32'd1);
`ifndef FB_DOUBLE_BUFFER_EN
        chk("rd_3_2_data", 32'(bus.r_data), 32'hA5);
`endif
        idle();
        chk("rvalid_drops", 32'(bus.r_valid), 32'd0);

        // Out-of-range write must not alias onto (0,1) = address 176
        wr(0, 1, 8'h3C); wr(176, 0, 8'h11); idle();
        chk("oob_wr_pulse", 32'(bus.oob_err), 32'd1);
        idle();
        chk("oob_wr_one_cycle", 32'(bus.oob_err), 32'd0);
        rd(0, 144); idle();
        chk("oob_rd_data",  32'(bus.r_data),  32'd0);
        chk("oob_rd_valid", 32'(bus.r_valid), 32'd1);
        chk("oob_rd_pulse", 32'(bus.oob_err), 32'd1);
        rd(0, 1); idle();
`ifndef FB_DOUBLE_BUFFER_EN
        chk("no_alias_0_1", 32'(bus.r_data), 32'h3C);
`endif

        // Same-cycle read and write at (10,10) returns old data
        wr(10, 10, 8'h33);
        @(negedge clk); clr_in();
        bus.w_en = 1; bus.w_x = 8'd10; bus.w_y = 8'd10; bus.w_data = 8'h77;
        bus.r_en = 1; bus.r_x = 8'd10; bus.r_y = 8'd10;
        idle();
`ifndef FB_DOUBLE_BUFFER_EN
        chk("rw_same_old", 32'(bus.r_data), 32'h33);
`endif
        rd(10, 10); idle();
`ifndef FB_DOUBLE_BUFFER_EN
        chk("rw_same_new", 32'(bus.r_data), 32'h77);
`endif

        // Full clear to 0x1C with a dropped write and an ignored clear_req
        @(negedge clk); clr_in(); bus.clear_req = 1; bus.clear_color = 8'h1C;
        @(negedge clk); clr_in(); cnt = 0;
        while (bus.busy === 1'b1 && cnt < DEPTH + 16) begin
            cnt++;
            @(negedge clk); clr_in();
            if (cnt == 1000) begin
                bus.w_en = 1; bus.w_x = 8'd5; bus.w_y = 8'd5; bus.w_data = 8'hEE;
            end
            if (cnt == 1001) begin bus.clear_req = 1; bus.clear_color = 8'h00; end
            if (cnt == 2000) begin bus.r_en = 1; bus.r_x = 8'd3; bus.r_y = 8'd2; end
        end
        chk("clear_busy_cycles", 32'(cnt), 32'(DEPTH));
        rd(0, 0); idle();
`ifndef FB_DOUBLE_BUFFER_EN
        chk("clear_0_0", 32'(bus.r_data), 32'h1C);
`endif
        rd(175, 143); idle();
`ifndef FB_DOUBLE_BUFFER_EN
        chk("clear_175_143", 32'(bus.r_data), 32'h1C);
`endif
        rd(5, 5); idle();
`ifndef FB_DOUBLE_BUFFER_EN
        chk("clear_drops_write", 32'(bus.r_data), 32'h1C);
`endif
        chk("clear_done_busy", 32'(bus.busy), 32'd0);

        // Reset during clear cycle 100 aborts it; address 200 = (24,1)
        wr(24, 1, 8'h42);
        @(negedge clk); clr_in(); bus.clear_req = 1; bus.clear_color = 8'h99;
        @(negedge clk); clr_in();
        repeat (100) @(negedge clk);
        reset = 1;
        bus.r_en = 1; bus.r_x = 8'd0; bus.r_y = 8'd0;
        @(negedge clk); clr_in(); reset = 0;
        chk("abort_busy",   32'(bus.busy),    32'd0);
        chk("abort_rvalid", 32'(bus.r_valid), 32'd0);
        rd(99, 0); idle();
`ifndef FB_DOUBLE_BUFFER_EN
        chk("abort_addr_99", 32'(bus.r_data), 32'h99);
`endif
        rd(24, 1); idle();
`ifndef FB_DOUBLE_BUFFER_EN
        chk("abort_addr_200", 32'(bus.r_data), 32'h42);
`endif
        rd(100, 0); idle();
`ifndef FB_DOUBLE_BUFFER_EN
        chk("abort_addr_100", 32'(bus.r_data), 32'h1C);
`endif

`ifdef FB_DOUBLE_BUFFER_EN
        // Bank swapping: writes land in the back bank only
        @(negedge clk); clr_in(); bus.swap = 1; idle();
        chk("swap_to_1", 32'(bus.bank), 32'd1);
        wr(0, 0, 8'h21);
        @(negedge clk); clr_in(); bus.swap = 1; idle();
        chk("swap_to_0", 32'(bus.bank), 32'd0);
        wr(0, 0, 8'h5A); rd(0, 0); idle();
        chk("db_front_old", 32'(bus.r_data), 32'h21);
        @(negedge clk); clr_in(); bus.swap = 1; idle();
        chk("db_bank_1", 32'(bus.bank), 32'd1);
        rd(0, 0); idle();
        chk("db_front_new", 32'(bus.r_data), 32'h5A);

        // Swaps during a clear collapse into one toggle when busy falls
        @(negedge clk); clr_in(); bus.clear_req = 1; bus.clear_color = 8'h66;
        @(negedge clk); clr_in(); cnt = 0;
        while (bus.busy === 1'b1 && cnt < DEPTH + 16) begin
            cnt++;
            if (cnt == 5000) chk("db_bank_held", 32'(bus.bank), 32'd1);
            @(negedge clk); clr_in();
            if (cnt == 10 || cnt == 20) bus.swap = 1;
        end
        chk("db_clear_cycles", 32'(cnt), 32'(DEPTH));
        chk("db_bank_after_clear", 32'(bus.bank), 32'd0);
        rd(0, 0); idle();
        chk("db_cleared_front", 32'(bus.r_data), 32'h66);
`endif

        idle(); idle();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_buffer_ram.md
FRAME_BUFFER_RAM -- requirements
Module: frame_buffer_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter SCREEN_WIDTH, default 176, pixels per line.
REQ-003 SHALL have parameter SCREEN_HEIGHT, default 144, lines per frame.
REQ-004 SHALL have parameter COORD_W, default 8, width of each x/y coordinate port.
REQ-005 SHALL have derived constant DEPTH = SCREEN_WIDTH*SCREEN_HEIGHT and ADDR_W = clog2(DEPTH), 15 at defaults.
REQ-006 SHALL have port: clk  in  1  single clock for all logic.
REQ-007 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports: w_en in 1, w_x in COORD_W, w_y in COORD_W, w_data in DATA_W (pixel write request).
REQ-009 SHALL have ports: r_en in 1, r_x in COORD_W, r_y in COORD_W (pixel read request).
REQ-010 SHALL have ports: r_data out DATA_W, r_valid out 1 (read response).
REQ-011 SHALL have ports: clear_req in 1, clear_color in DATA_W (frame fill request).
REQ-012 SHALL have ports: busy out 1 (clear in progress), oob_err out 1 (out-of-range pulse).
REQ-013 SHALL have ports: swap in 1 (bank swap request), bank out 1 (current front bank).

Function
REQ-014 Address SHALL be y*SCREEN_WIDTH + x, ADDR_W bits, no wrap; coordinates with x>=SCREEN_WIDTH or y>=SCREEN_HEIGHT are out of range.
REQ-015 In-range write with w_en=1 and busy=0 SHALL update memory at that clock edge.
REQ-016 Read latency SHALL be 1: r_data and r_valid asserted the cycle after r_en=1; r_valid SHALL be low otherwise.
REQ-017 Read and write to the same address in the same cycle SHALL return the old data.
REQ-018 Out-of-range write SHALL be dropped; out-of-range read SHALL return r_data=0 with r_valid=1; either SHALL pulse oob_err high for exactly one cycle, aligned with r_valid timing.
REQ-019 Clear FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on clear_req=1, latching clear_color.
REQ-020 In CLEAR, an ADDR_W counter SHALL write the latched color to addresses 0..DEPTH-1, one per cycle, then return to IDLE; busy=1 exactly DEPTH cycles.
REQ-021 During CLEAR, external writes SHALL be dropped without oob_err; reads SHALL be serviced normally; clear_req SHALL be ignored.
REQ-022 Memory SHALL be inferred as block RAM (M9K); contents SHALL NOT be reset.

Reset
REQ-023 On reset=1: FSM->IDLE, counter=0, r_data=0, r_valid=0, busy=0, oob_err=0, bank=0, pending swap cleared, effective next cycle.
REQ-024 Reset asserted mid-clear SHALL abort the clear; memory keeps partially cleared contents.

Configuration
REQ-025 Macro FB_DOUBLE_BUFFER_EN defined: two banks of DEPTH words; writes and clears target back bank (~bank), reads target front bank (bank).
REQ-026 With FB_DOUBLE_BUFFER_EN: swap=1 in IDLE SHALL toggle bank at that edge; swap during CLEAR SHALL be held pending and applied the cycle the FSM returns to IDLE; multiple swaps while pending collapse to one.
REQ-027 Without FB_DOUBLE_BUFFER_EN: single bank shared by reads and writes, swap ignored, bank tied 0.

Verification
REQ-028 Reset; write (3,2)=0xA5; r_en (3,2) next cycle -> following cycle r_data=0xA5, r_valid=1, address 355.
REQ-029 Write (176,0)=0x11 -> dropped, oob_err one-cycle pulse; read (0,144) -> r_data=0x00, r_valid=1, oob_err pulse.
REQ-030 clear_req with clear_color=0x1C -> busy high exactly 25344 cycles; then reads (0,0),(175,143) return 0x1C; write issued mid-clear absent afterward.
REQ-031 Same-cycle write 0x77 and read at (10,10) holding 0x33 -> r_data=0x33; next read -> 0x77.
REQ-032 FB_DOUBLE_BUFFER_EN: write (0,0)=0x5A, read -> old value; swap -> bank=1, read (0,0) -> 0x5A; swap during clear -> bank toggles only when busy falls.
REQ-033 reset asserted at clear cycle 100 -> busy=0, r_valid=0 next cycle; address 99 holds clear color, address 200 unchanged.
